pipelined_shifter: RTL and testbench

- Parametrised, pipelined successor to the single-cycle 32-bit barrel shifter in the ALU datapath.
- Performs SRA, SRL, SLL and ROR on a WIDTH-bit operand through log2(WIDTH) mux levels, split across PIPE register stages.
- Produces an ARM-style carry-out (last bit shifted out) and a zero flag.
- Sits between operand fetch and writeback, with valid/ready handshakes on both sides so the execute stage can be stalled.

---
 rtl/pipelined_shifter_if.sv | 28 ++
 rtl/pipelined_shifter.sv | 175 +++++++++++++++++
 tb/tb_pipelined_shifter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipelined_shifter_if.sv
// Operand/result handshake bundle for pipelined_shifter: operand beat in, shifted result out.
interface pipelined_shifter_if #(
   parameter int unsigned WIDTH = 32
);
   localparam int unsigned SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [SHW:0]     in_shamt;
   logic [1:0]       in_mode;
   logic             in_carry;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_c;
   logic             out_carry;
   logic             out_zero;

   modport master (
      output in_valid, in_a, in_shamt, in_mode, in_carry, out_ready,
      input  in_ready, out_valid, out_c, out_carry, out_zero
   );

   modport slave (
      input  in_valid, in_a, in_shamt, in_mode, in_carry, out_ready,
      output in_ready, out_valid, out_c, out_carry, out_zero
   );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined SRA/SRL/SLL/ROR barrel shifter with ARM-style carry-out and zero flag.
// Optional macro SHIFT_AMT_SAT_EN honours the full shift amount with saturation at >= WIDTH.
module pipelined_shifter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned PIPE  = 2
) (
   input logic                clk,
   input logic                rst,
   pipelined_shifter_if.slave bus
);
   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned LPS = (SHW + PIPE - 1) / PIPE;

   localparam logic [1:0] MODE_SRA = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SLL = 2'b10;

   logic en;
   logic out_valid;

   // One mux level: returns {carry_out, result} for a shift by sh = 2^k.
   function automatic logic [WIDTH:0] level_op(input logic [WIDTH-1:0] a,
                                               input logic [1:0]       mode,
                                               input int unsigned      k);
      int unsigned      sh;
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] t;
      logic             c;
      sh = 32'(1) << k;
      case (mode)
         MODE_SRA: begin
            r = $unsigned($signed(a) >>> sh);
            t = a >> (sh - 1);
            c = t[0];
         end
         MODE_SRL: begin
            r = a >> sh;
            t = a >> (sh - 1);
            c = t[0];
         end
         MODE_SLL: begin
            r = a << sh;
            t = a << (sh - 1);
            c = t[WIDTH-1];
         end
         default: begin
            r = (a >> sh) | (a << (WIDTH - sh));
            c = r[WIDTH-1];
         end
      endcase
      return {c, r};
   endfunction

   for (genvar s = 0; s < PIPE; s++) begin : g_stage
      localparam int unsigned LO = 32'(s) * LPS;
      localparam int unsigned HI = ((32'(s) + 1) * LPS < SHW) ? (32'(s) + 1) * LPS : SHW;

      logic             valid_in;
      logic [WIDTH-1:0] a_in;
      logic [SHW-1:0]   shamt_in;
      logic [1:0]       mode_in;
      logic             carry_in;

      logic [WIDTH-1:0] a_d;
      logic             carry_d;

      logic             valid_q;
      logic [WIDTH-1:0] a_q;
      logic [SHW-1:0]   shamt_q;
      logic [1:0]       mode_q;
      logic             carry_q;

      if (s == 0) begin : g_head
`ifdef SHIFT_AMT_SAT_EN
         logic amt_is_width;
         assign amt_is_width = (bus.in_shamt[SHW-1:0] == '0);
`else
         logic unused_shamt_msb;
         assign unused_shamt_msb = bus.in_shamt[SHW];
`endif
         // Saturation collapses into stage-0 operands: preloaded result, zero residual amount.
         always_comb begin
            valid_in = bus.in_valid;
            a_in     = bus.in_a;
            shamt_in = bus.in_shamt[SHW-1:0];
            mode_in  = bus.in_mode;
            carry_in = bus.in_carry;
`ifdef SHIFT_AMT_SAT_EN
            if (bus.in_shamt[SHW]) begin
               case (bus.in_mode)
                  MODE_SRA: begin
                     a_in     = {WIDTH{bus.in_a[WIDTH-1]}};
                     carry_in = bus.in_a[WIDTH-1];
                     shamt_in = '0;
                  end
                  MODE_SRL: begin
                     a_in     = '0;
                     carry_in = amt_is_width & bus.in_a[WIDTH-1];
                     shamt_in = '0;
                  end
                  MODE_SLL: begin
                     a_in     = '0;
                     carry_in = amt_is_width & bus.in_a[0];
                     shamt_in = '0;
                  end
                  default: begin
                     if (amt_is_width) carry_in = bus.in_a[WIDTH-1];
                  end
               endcase
            end
`endif
         end
      end else begin : g_body
         assign valid_in = g_stage[s-1].valid_q;
         assign a_in     = g_stage[s-1].a_q;
         assign shamt_in = g_stage[s-1].shamt_q;
         assign mode_in  = g_stage[s-1].mode_q;
         assign carry_in = g_stage[s-1].carry_q;
      end

      // Mux levels owned by this stage, shift-by-1 level first.
      always_comb begin
         logic [WIDTH:0] lvl;
         a_d     = a_in;
         carry_d = carry_in;
         lvl     = '0;
         for (int unsigned k = LO; k < HI; k++) begin
            if (((shamt_in >> k) & SHW'(1)) != '0) begin
               lvl     = level_op(a_d, mode_in, k);
               a_d     = lvl[WIDTH-1:0];
               carry_d = lvl[WIDTH];
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            shamt_q <= '0;
            mode_q  <= '0;
            carry_q <= 1'b0;
         end else if (en) begin
            valid_q <= valid_in;
            a_q     <= a_d;
            shamt_q <= shamt_in;
            mode_q  <= mode_in;
            carry_q <= carry_d;
         end
      end

      if (s == PIPE - 1) begin : g_tail
         logic zero_q;
         logic unused_tail;
         assign unused_tail = ^{shamt_q, mode_q};

         always_ff @(posedge clk) begin
            if (rst) begin
               zero_q <= 1'b1;
            end else if (en) begin
               zero_q <= (a_d == '0);
            end
         end
      end
   end

   // Single global advance: the whole pipe moves unless the result is held.
   assign out_valid     = g_stage[PIPE-1].valid_q;
   assign en            = ~out_valid | bus.out_ready;
   assign bus.in_ready  = en;
   assign bus.out_valid = out_valid;
   assign bus.out_c     = g_stage[PIPE-1].a_q;
   assign bus.out_carry = g_stage[PIPE-1].carry_q;
   assign bus.out_zero  = g_stage[PIPE-1].g_tail.zero_q;
endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter (WIDTH=32, PIPE=2): vector table plus stall/reset sequences.
module tb_pipelined_shifter;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned PIPE  = 2;
`ifdef SHIFT_AMT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipelined_shifter_if #(.WIDTH(WIDTH)) bus ();
   pipelined_shifter #(.WIDTH(WIDTH), .PIPE(PIPE)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [1:0]  mode;
      logic [31:0] a;
      logic [5:0]  shamt;
      logic        cin;
      logic [31:0] exp_c;
      logic        exp_carry;
      logic        exp_zero;
   } vec_t;

   vec_t vecs[15];
   vec_t bp[3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h required=%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.in_mode  = v.mode;
      bus.in_a     = v.a;
      bus.in_shamt = v.shamt;
      bus.in_carry = v.cin;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      drive(v);
      bus.in_valid = 1'b1;
      @(negedge clk);
      check({v.name, " in_ready"}, 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check({v.name, " early"}, 32'(bus.out_valid), 32'd0);
      tick();
      check({v.name, " valid"}, 32'(bus.out_valid), 32'd1);
      check({v.name, " c"}, bus.out_c, v.exp_c);
      check({v.name, " carry"}, 32'(bus.out_carry), 32'(v.exp_carry));
      check({v.name, " zero"}, 32'(bus.out_zero), 32'(v.exp_zero));
      tick();
      check({v.name, " drained"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int nb;
      int ngot;
      vecs[0]  = '{"sra3",    2'b00, 32'h8000001C, 6'd3,  1'b0, 32'hF0000003, 1'b1, 1'b0};
      vecs[1]  = '{"ror1",    2'b11, 32'h00000001, 6'd1,  1'b0, 32'h80000000, 1'b1, 1'b0};
      vecs[2]  = '{"srl1",    2'b01, 32'h00000001, 6'd1,  1'b0, 32'h00000000, 1'b1, 1'b1};
      vecs[3]  = '{"sll0",    2'b10, 32'h80000001, 6'd0,  1'b1, 32'h80000001, 1'b1, 1'b0};
      vecs[4]  = '{"sll4",    2'b10, 32'h12345678, 6'd4,  1'b0, 32'h23456780, 1'b1, 1'b0};
      vecs[5]  = '{"srl31",   2'b01, 32'hF0000000, 6'd31, 1'b0, 32'h00000001, 1'b1, 1'b0};
      vecs[6]  = '{"ror8",    2'b11, 32'h12345678, 6'd8,  1'b1, 32'h78123456, 1'b0, 1'b0};
      vecs[7]  = '{"sra31",   2'b00, 32'h7FFFFFFF, 6'd31, 1'b0, 32'h00000000, 1'b1, 1'b1};
      vecs[8]  = '{"ror0",    2'b11, 32'hA5A5A5A5, 6'd0,  1'b0, 32'hA5A5A5A5, 1'b0, 1'b0};
      vecs[9]  = '{"sll1",    2'b10, 32'hFFFFFFFF, 6'd1,  1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
      vecs[10] = '{"sll33",   2'b10, 32'h00000003, 6'd33, 1'b0,
                   SAT ? 32'h0 : 32'h6, 1'b0, SAT};
      vecs[11] = '{"sra40",   2'b00, 32'h80000000, 6'd40, 1'b0,
                   SAT ? 32'hFFFFFFFF : 32'hFF800000, SAT, 1'b0};
      vecs[12] = '{"ror32",   2'b11, 32'h80000001, 6'd32, 1'b0, 32'h80000001, SAT, 1'b0};
      vecs[13] = '{"srl32",   2'b01, 32'h80000000, 6'd32, 1'b0,
                   SAT ? 32'h0 : 32'h80000000, SAT, SAT};
      vecs[14] = '{"sll32",   2'b10, 32'h00000001, 6'd32, 1'b0,
                   SAT ? 32'h0 : 32'h1, SAT, SAT};

      bp[0] = '{"bp0", 2'b01, 32'hFFFF0000, 6'd4,  1'b0, 32'h0FFFF000, 1'b0, 1'b0};
      bp[1] = '{"bp1", 2'b10, 32'h000000FF, 6'd28, 1'b0, 32'hF0000000, 1'b1, 1'b0};
      bp[2] = '{"bp2", 2'b11, 32'h000000F0, 6'd4,  1'b0, 32'h0000000F, 1'b0, 1'b0};

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drive(vecs[0]);
      repeat (2) tick();
      rst = 1'b0;

      // Reset state and idle behaviour.
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst in_ready", 32'(bus.in_ready), 32'd1);
      check("rst out_zero", 32'(bus.out_zero), 32'd1);
      check("rst out_c", bus.out_c, 32'd0);
      check("rst out_carry", 32'(bus.out_carry), 32'd0);
      repeat (3) begin
         tick();
         check("idle out_valid", 32'(bus.out_valid), 32'd0);
      end

      foreach (vecs[i]) run_vec(vecs[i]);

      // Back-to-back beats with the consumer stalled for four cycles.
      nb   = 0;
      ngot = 0;
      for (int cyc = 0; cyc < 30 && ngot < 3; cyc++) begin
         bus.out_ready = (cyc >= 4);
         bus.in_valid  = (nb < 3);
         if (nb < 3) drive(bp[nb]);
         @(negedge clk);
         if (bus.out_valid && !bus.out_ready) begin
            check("stall in_ready", 32'(bus.in_ready), 32'd0);
            check("stall hold c", bus.out_c, bp[ngot].exp_c);
         end
         if (bus.out_valid && bus.out_ready) begin
            check({bp[ngot].name, " c"}, bus.out_c, bp[ngot].exp_c);
            check({bp[ngot].name, " carry"}, 32'(bus.out_carry), 32'(bp[ngot].exp_carry));
            ngot++;
         end
         if (bus.in_valid && bus.in_ready) nb++;
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("bp accepted", 32'(nb), 32'd3);
      check("bp delivered", 32'(ngot), 32'd3);
      repeat (2) begin
         tick();
         check("bp no dup", 32'(bus.out_valid), 32'd0);
      end

      // Reset with two beats in flight; neither may be delivered.
      bus.out_ready = 1'b0;
      drive('{"x", 2'b10, 32'h00000001, 6'd31, 1'b0, 32'h0, 1'b0, 1'b0});
      bus.in_valid = 1'b1;
      tick();
      drive('{"y", 2'b01, 32'h00000080, 6'd7, 1'b0, 32'h0, 1'b0, 1'b0});
      tick();
      bus.in_valid = 1'b0;
      check("flight held", 32'(bus.out_valid), 32'd1);
      check("flight in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
      check("mid rst out_c", bus.out_c, 32'd0);
      check("mid rst out_zero", 32'(bus.out_zero), 32'd1);
      bus.out_ready = 1'b1;
      repeat (3) begin
         tick();
         check("post rst silent", 32'(bus.out_valid), 32'd0);
      end
      run_vec('{"post rst ror", 2'b11, 32'h00000003, 6'd1, 1'b0, 32'h80000001, 1'b1, 1'b0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
